// File: rtl/gate_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker_if
// Bundles the run-control, operand and result signals between the sweep
// checker and the basic-gate block it exercises (and whoever starts it).
//   start      run request (sampled on clk)
//   a, b       operands driven to the gate block
//   y          7-bit gate block result
//   busy       sweep in progress
//   done       one-cycle completion pulse
//   pass       last completed sweep had no mismatched bits
//   err_count  saturating total of mismatched bits
//   fail_mask  sticky OR of mismatched bit positions
// master: the checker.  slave: the environment (requester + gate block).
// ---------------------------------------------------------------------------
interface gate_sweep_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic [6:0]       y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [6:0]       fail_mask;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, err_count, fail_mask
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, err_count, fail_mask
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker
// On an accepted start, drives {a,b} through 00,01,10,11, holds each pair for
// SETTLE cycles, samples y and compares it against the expected seven gate
// outputs. Reports a sticky fail mask, a saturating mismatch count and a pass
// flag, with a one-cycle done pulse at the end of the sweep.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   gate_sweep_checker_if.master (start, y in; a, b, busy, done,
//         pass, err_count, fail_mask out -- all outputs registered)
// Parameters:
//   SETTLE  cycles each operand pair is held before sampling (0 acts as 1)
//   ERR_W   width of err_count
// ---------------------------------------------------------------------------
module gate_sweep_checker #(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_sweep_checker_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam int               CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    RELOAD  = (SETTLE > 1) ? CW'(SETTLE - 1) : CW'(0);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    // Sum width leaves headroom for adding up to 7 to a full-scale count.
    localparam int               SW      = ERR_W + 4;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // Expected gate outputs for the operands currently being driven.
    function automatic logic [6:0] exp_vec(input logic a, input logic b);
        exp_vec = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    endfunction

    // Number of set bits in a 7-bit mismatch vector.
    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 7; i++) begin
            c = c + {2'b00, v[i]};
        end
        popcount7 = c;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [6:0]       mask_q, mask_d;

    logic [6:0]       mism_s;
    logic [SW-1:0]    sum_s;
    logic [ERR_W-1:0] err_sat_s;

    // Mismatch of the current sample and the saturated running total.
    always_comb begin
        mism_s = bus.y ^ exp_vec(idx_q[1], idx_q[0]);
        sum_s  = SW'(err_q) + SW'(popcount7(mism_s));
        if (sum_s > SW'(ERR_MAX)) begin
            err_sat_s = ERR_MAX;
        end else begin
            err_sat_s = sum_s[ERR_W-1:0];
        end
    end

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;
        case (state_q)
            // FINISH accepts a start exactly like IDLE so sweeps can chain.
            S_IDLE, S_FINISH: begin
                if (bus.start) begin
                    state_d = S_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = RELOAD;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = {ERR_W{1'b0}};
                    mask_d  = 7'd0;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    mask_d = mask_q | mism_s;
                    err_d  = err_sat_s;
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = RELOAD;
                    end else begin
                        // Operands stay at 1,1 until the next start.
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_sat_s == {ERR_W{1'b0}});
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= CW'(0);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= {ERR_W{1'b0}};
            mask_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.a         = idx_q[1];
    assign bus.b         = idx_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker
// Two checkers (ERR_W=8 and ERR_W=3, SETTLE=2) run side by side against a
// behavioural gate block whose output can be corrupted per operand pair via
// an XOR fault table. Expected sweep results are pushed at each start; a
// monitor checks operand sequencing every cycle and pops/compares at done.
// ---------------------------------------------------------------------------
module tb_gate_sweep_checker;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [6:0] xm [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gate_sweep_checker_if #(.ERR_W(8)) if8 ();
    gate_sweep_checker_if #(.ERR_W(3)) if3 ();

    gate_sweep_checker #(.SETTLE(S), .ERR_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.master));
    gate_sweep_checker #(.SETTLE(S), .ERR_W(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

    function automatic logic [6:0] gate_ref(input logic a, input logic b);
        logic [6:0] y;
        y[0] = ~a;
        y[1] = a & b;
        y[2] = a | b;
        y[3] = ~(a & b);
        y[4] = ~(a | b);
        y[5] = a ^ b;
        y[6] = ~(a ^ b);
        return y;
    endfunction

    assign if8.start = start;
    assign if3.start = start;
    assign if8.y = gate_ref(if8.a, if8.b) ^ xm[{if8.a, if8.b}];
    assign if3.y = gate_ref(if3.a, if3.b) ^ xm[{if3.a, if3.b}];

    typedef struct {
        int start_cyc;
        int done_cyc;
        int err;
        int mask;
        int pass;
    } exp_t;

    exp_t q8[$];
    exp_t q3[$];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Expected results from the fault table: sum over the four pairs.
    task automatic push_expect(input int start_cyc);
        exp_t e;
        int   total;
        int   m;
        total = 0;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            total += $countones(xm[i]);
            m |= int'(xm[i]);
        end
        e.start_cyc = start_cyc;
        e.done_cyc  = start_cyc + 4 * S;
        e.mask      = m;
        e.pass      = (total == 0) ? 1 : 0;
        e.err       = (total > 255) ? 255 : total;
        q8.push_back(e);
        e.err       = (total > 7) ? 7 : total;
        q3.push_back(e);
    endtask

    task automatic mon(input int k, input logic a, input logic b, input logic busy,
                       input logic done, input logic pass, input int err, input int mask);
        exp_t e;
        int   have;
        int   j;
        have = (k == 0) ? q8.size() : q3.size();
        if (have > 0) begin
            e = (k == 0) ? q8[0] : q3[0];
        end
        if (done) begin
            if (have == 0) begin
                chk($sformatf("unexpected_done[%0d]", k), 1, 0);
            end else begin
                if (k == 0) void'(q8.pop_front()); else void'(q3.pop_front());
                chk($sformatf("done_cycle[%0d]", k), cyc, e.done_cyc);
                chk($sformatf("err_count[%0d]", k), err, e.err);
                chk($sformatf("fail_mask[%0d]", k), mask, e.mask);
                chk($sformatf("pass[%0d]", k), int'(pass), e.pass);
                chk($sformatf("busy_at_done[%0d]", k), int'(busy), 0);
            end
        end else if (have > 0) begin
            j = cyc - e.start_cyc;
            if (j >= 0 && j < 4 * S) begin
                chk($sformatf("ab_seq[%0d]", k), int'({a, b}), j / S);
                chk($sformatf("busy[%0d]", k), int'(busy), 1);
            end
        end else begin
            chk($sformatf("idle_busy[%0d]", k), int'(busy), 0);
        end
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if8.a, if8.b, if8.busy, if8.done, if8.pass, int'(if8.err_count), int'(if8.fail_mask));
            mon(1, if3.a, if3.b, if3.busy, if3.done, if3.pass, int'(if3.err_count), int'(if3.fail_mask));
        end
    end

    function automatic int outs8();
        return int'({if8.a, if8.b, if8.busy, if8.done, if8.pass, if8.err_count, if8.fail_mask});
    endfunction

    function automatic int outs3();
        return int'({if3.a, if3.b, if3.busy, if3.done, if3.pass, if3.err_count, if3.fail_mask});
    endfunction

    task automatic set_faults(input int mode);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            case (mode)
                0: xm[i] = 7'h00;
                1: xm[i] = gate_ref(ab[1], ab[0]) & 7'h20;
                2: xm[i] = 7'h7F;
                default: xm[i] = ($urandom_range(0, 3) == 0) ? 7'(0) : 7'($urandom_range(0, 127));
            endcase
        end
    endtask

    task automatic issue_start();
        @(negedge clk);
        start = 1'b1;
        push_expect(cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (q8.size() + q3.size()) != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("sweep_timeout", q8.size() + q3.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_faults(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        repeat (10) begin
            @(negedge clk);
            chk("reset_idle8", outs8(), 0);
            chk("reset_idle3", outs3(), 0);
        end

        // Directed: correct, y[5] stuck at 0, all bits inverted.
        for (int mode = 0; mode < 3; mode++) begin
            set_faults(mode);
            issue_start();
            wait_drain();
        end

        // start re-pulsed mid-sweep must not disturb the sweep.
        set_faults(3);
        issue_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // start in the done cycle: inverted sweep chained into a clean one.
        set_faults(2);
        issue_start();
        for (int i = 0; i < 40 && !if8.done; i++) @(negedge clk);
        chk("done_seen", int'(if8.done), 1);
        set_faults(0);
        start = 1'b1;
        push_expect(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("restart_ab", int'({if8.a, if8.b, if8.err_count, if8.fail_mask, if8.pass}), 0);
        wait_drain();

        // Asynchronous reset after vector 1 has been sampled.
        set_faults(2);
        issue_start();
        for (int i = 0; i < 40 && (cyc - q8[0].start_cyc) < 5; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        q8.delete();
        q3.delete();
        #1;
        chk("async_rst8", outs8(), 0);
        chk("async_rst3", outs3(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_faults(0);
        issue_start();
        wait_drain();

        // Randomised sweeps.
        for (int n = 0; n < 8; n++) begin
            set_faults(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue_start();
            wait_drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus-and-capture stage wrapped around the seven-output basic-gate block (y[0]=~a, y[1]=a&b, y[2]=a|b, y[3]=~(a&b), y[4]=~(a|b), y[5]=a^b, y[6]=~(a^b)). On a start pulse it drives the gate block's `a`/`b` inputs through all four combinations, waits a programmable settle time, and samples the returned 7-bit `y` vector. It compares each sample against an internally computed expected vector and reports a sticky per-gate fail mask, a saturating mismatch count and a pass flag.

## Interface
- SETTLE, 2: cycles each operand pair is held before `y` is sampled; legal ≥1, value 0 behaves as 1
- ERR_W, 8: width of `err_count`
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  run request, sampled on clk; honoured only when not busy
- a  output  1  operand a to gate block
- b  output  1  operand b to gate block
- y  input  7  gate block result vector
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse at sweep completion
- pass  output  1  1 when the last completed sweep had zero mismatched bits
- err_count  output  ERR_W  total mismatched bits in current/last sweep, saturating
- fail_mask  output  7  sticky OR of mismatched bit positions in current/last sweep

## Operation
- One clock; reset is asynchronous and active-high.
- Reset: state IDLE. a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, settle counter=0, vector index=0.
- States are IDLE, SETTLE and FINISH.
- IDLE: start=1 at an edge → index=0, {a,b}=2'b00, err_count=0, fail_mask=0, pass=0, busy=1, counter=SETTLE-1, go to SETTLE.
- SETTLE: counter≠0 → decrement. Counter=0 → sample y and compute mismatch m = y ^ exp.
  - exp = {~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b, ~a}, using the currently driven a,b.
  - fail_mask |= m.
  - err_count += popcount(m), saturating at 2^ERR_W-1.
  - If index<3: index++, {a,b}=next index (order 00,01,10,11; a is the MSB), counter reloads to SETTLE-1.
  - If index=3: go to FINISH.
- FINISH lasts one cycle: done=1, busy=0, pass=1 iff (err_count==0 and m==0 for the final sample, i.e. the final updated total is zero). It then returns to IDLE. a and b hold 1,1 until the next start.
- done is asserted only in FINISH. A start sampled during the done cycle is accepted immediately, as from IDLE: done drops, and counters and pass clear.
- start while busy is ignored, with no effect on the sweep.
- Reset mid-sweep aborts immediately to the reset values, with no done pulse.
- err_count maximum without saturation is 28, so ERR_W≥5 never saturates. The saturating add must not wrap.

## Timing
- The start edge E0 drives vector 0. Vector k is sampled at edge E0+(k+1)·SETTLE. The next vector's a/b change on that same edge.
- Final sample at E0+4·SETTLE. FINISH (done=1, busy=0, pass valid) is registered from that edge and lasts exactly one cycle.
- SETTLE=2: samples at E0+2, +4, +6, +8, and done is high in the cycle after edge E0+8.
- busy rises in the cycle after E0 and falls when done rises.
- err_count and fail_mask update at each sample edge and are stable between samples. They hold after done until the next accepted start.
- y is treated as combinational from a, b. Latency tolerance is set solely by SETTLE.

## Test plan
- Reset, then release with start=0 → a=b=busy=done=pass=0, err_count=0, fail_mask=0 for 10 cycles.
- Correct gate block, SETTLE=2, one start pulse → a,b=00,01,10,11, each held 2 cycles; done exactly one cycle, 8 cycles after the start edge; pass=1, err_count=0, fail_mask=0.
- y[5] forced 0 → mismatches at 01 and 10; err_count=2, fail_mask=7'b0100000, pass=0.
- y forced to ~exp (all bits inverted), ERR_W=8 → err_count=28, fail_mask=7'h7F, pass=0. Repeat with ERR_W=3 → err_count=7 (saturated, no wrap).
- start re-pulsed mid-sweep → sweep timing unchanged. start asserted in the done cycle → new sweep begins at that edge, err_count/fail_mask/pass cleared, vector 00 driven.
- rst asserted asynchronously (between clock edges) after vector 1 sampled → all outputs return to reset values immediately, no done pulse. A subsequent start yields a full correct sweep.
